acc_round_scheduler: RTL and testbench

- Sequences the accumulator datapath through a blind-rotation loop: one AddToACAP run per LWE coefficient.
- Issues a single-cycle start per iteration and waits for the accumulator's done.
- Advances the key base address and skips iterations whose coefficient is zero.
- Sits between the bootstrapping top-level controller and the accumulator block; supervises each run with a timeout and supports abort.

---
 rtl/acc_round_scheduler.sv | 164 ++++++++++++++++
 tb/tb_acc_round_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_round_scheduler.sv
// Blind-rotation loop sequencer: one accumulator run per LWE coefficient, skipping
// zero coefficients, with a per-run watchdog and an abort path back to IDLE.
//
// state  | meaning
// IDLE   | waiting for start; a zero iteration count just pulses done
// ISSUE  | sample coeff_zero; launch an accumulator run or skip the coefficient
// WAIT   | accumulator running; the watchdog counts down to its terminal count
// NEXT   | advance iteration index and key base, or finish on the last index
// FINISH | done pulse is visible; return to IDLE
module acc_round_scheduler #(
    parameter int ITER_W     = 10,
    parameter int KEY_ADDR_W = 12,
    parameter int KEY_STRIDE = 8,
    parameter int TIMEOUT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ITER_W-1:0]     iter_count,
    input  logic                  coeff_zero,
    input  logic                  abort,
    input  logic                  acc_done,
    output logic                  acc_start,
    output logic [KEY_ADDR_W-1:0] key_base,
    output logic [ITER_W-1:0]     iter_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic                  timeout_err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_NEXT   = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    // Loaded so that terminal count is reached after 2^TIMEOUT_W-1 WAIT cycles.
    localparam logic [TIMEOUT_W-1:0] WD_LOAD = ~TIMEOUT_W'(1);

    logic [2:0]            state_q, state_d;
    logic [ITER_W-1:0]     count_q, count_d;
    logic [ITER_W-1:0]     iter_idx_q, iter_idx_d;
    logic [KEY_ADDR_W-1:0] key_base_q, key_base_d;
    logic [TIMEOUT_W-1:0]  wd_q, wd_d;
    logic                  acc_start_q, acc_start_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  aborted_q, aborted_d;
    logic                  timeout_err_q, timeout_err_d;

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        iter_idx_d    = iter_idx_q;
        key_base_d    = key_base_q;
        wd_d          = wd_q;
        timeout_err_d = timeout_err_q;
        acc_start_d   = 1'b0;
        done_d        = 1'b0;
        aborted_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (iter_count != '0) begin
                        count_d       = iter_count;
                        iter_idx_d    = '0;
                        key_base_d    = '0;
                        timeout_err_d = 1'b0;
                        state_d       = S_ISSUE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (coeff_zero) begin
                    state_d = S_NEXT;
                end else begin
                    acc_start_d = 1'b1;
                    wd_d        = WD_LOAD;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (acc_done) begin
                    state_d = S_NEXT;
                end else if (wd_q == '0) begin
                    timeout_err_d = 1'b1;
                    aborted_d     = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    wd_d = wd_q - TIMEOUT_W'(1);
                end
            end
            S_NEXT: begin
                if (iter_idx_q == count_q - ITER_W'(1)) begin
                    done_d  = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    iter_idx_d = iter_idx_q + ITER_W'(1);
                    key_base_d = key_base_q + KEY_ADDR_W'(KEY_STRIDE);
                    state_d    = S_ISSUE;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides whatever the active state decided, including a watchdog expiry.
        if (abort && (state_q != S_IDLE)) begin
            state_d       = S_IDLE;
            iter_idx_d    = iter_idx_q;
            key_base_d    = key_base_q;
            wd_d          = wd_q;
            timeout_err_d = timeout_err_q;
            acc_start_d   = 1'b0;
            done_d        = 1'b0;
            aborted_d     = 1'b1;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            iter_idx_q    <= '0;
            key_base_q    <= '0;
            wd_q          <= '0;
            acc_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            iter_idx_q    <= iter_idx_d;
            key_base_q    <= key_base_d;
            wd_q          <= wd_d;
            acc_start_q   <= acc_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            aborted_q     <= aborted_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign acc_start   = acc_start_q;
    assign key_base    = key_base_q;
    assign iter_idx    = iter_idx_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign aborted     = aborted_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_acc_round_scheduler.sv
// Scoreboard bench for acc_round_scheduler: each run is planned from the loop rules,
// expected output events are queued with their cycle, and a monitor checks them.
module tb_acc_round_scheduler;

    localparam int ITER_W     = 10;
    localparam int KEY_ADDR_W = 12;
    localparam int KEY_STRIDE = 8;
    localparam int TW         = 5;
    localparam int WD_LIMIT   = (1 << TW) - 1;

    localparam logic [2:0] K_START = 3'b100;
    localparam logic [2:0] K_DONE  = 3'b010;
    localparam logic [2:0] K_ABORT = 3'b001;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic [ITER_W-1:0]     iter_count = '0;
    logic                  coeff_zero = 1'b0;
    logic                  abort = 1'b0;
    logic                  acc_done = 1'b0;
    logic                  acc_start;
    logic [KEY_ADDR_W-1:0] key_base;
    logic [ITER_W-1:0]     iter_idx;
    logic                  busy;
    logic                  done;
    logic                  aborted;
    logic                  timeout_err;

    acc_round_scheduler #(
        .ITER_W(ITER_W), .KEY_ADDR_W(KEY_ADDR_W), .KEY_STRIDE(KEY_STRIDE), .TIMEOUT_W(TW)
    ) dut (
        .clk(clk), .reset(rst), .start(start), .iter_count(iter_count),
        .coeff_zero(coeff_zero), .abort(abort), .acc_done(acc_done),
        .acc_start(acc_start), .key_base(key_base), .iter_idx(iter_idx),
        .busy(busy), .done(done), .aborted(aborted), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] kind;
        int         edge_n;
        int         key;
        int         idx;
        logic       terr;
        logic       busy;
    } ev_t;

    ev_t  sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   m_key = 0;
    int   m_idx = 0;
    logic m_terr = 1'b0;
    int   m_mask[$];
    int   m_dly[$];
    logic pl_start[$];
    logic pl_cz[$];
    logic pl_ad[$];
    logic pl_ab[$];
    int   pl_cnt[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic ev_t mk_ev(input logic [2:0] kind, input int edge_n, input int key,
                                  input int idx, input logic terr, input logic bsy);
        ev_t r;
        r.kind = kind; r.edge_n = edge_n; r.key = key; r.idx = idx; r.terr = terr; r.busy = bsy;
        return r;
    endfunction

    // Monitor: any output pulse must match the oldest expected event, at its cycle.
    always @(negedge clk) begin : monitor
        ev_t e;
        while (sb.size() > 0 && sb[0].edge_n < cyc) begin
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL missed_event actual=none required=kind %b at cycle %0d", e.kind, e.edge_n);
        end
        if (acc_start || done || aborted) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event actual=kind %b required=none (cycle %0d)",
                         {acc_start, done, aborted}, cyc);
            end else begin
                e = sb.pop_front();
                chk("ev_kind", 32'({acc_start, done, aborted}), 32'(e.kind));
                chk("ev_cycle", cyc, e.edge_n);
                chk("ev_key_base", 32'(key_base), e.key);
                chk("ev_iter_idx", 32'(iter_idx), e.idx);
                chk("ev_timeout_err", 32'(timeout_err), 32'(e.terr));
                chk("ev_busy", 32'(busy), 32'(e.busy));
            end
        end
    end

    task automatic ensure(input int k);
        while (pl_start.size() <= k) begin
            pl_start.push_back(1'b0);
            pl_cz.push_back(1'($urandom));
            pl_ad.push_back(1'b0);
            pl_ab.push_back(1'b0);
            pl_cnt.push_back(int'($urandom_range(1023, 0)));
        end
    endtask

    task automatic drive(input int k);
        start      = pl_start[k];
        iter_count = ITER_W'(pl_cnt[k]);
        coeff_zero = pl_cz[k];
        acc_done   = pl_ad[k];
        abort      = pl_ab[k];
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0; acc_done = 1'b0; coeff_zero = 1'b0; iter_count = '0;
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_acc_start", 32'(acc_start), 0);
        chk("rst_key_base", 32'(key_base), 0);
        chk("rst_iter_idx", 32'(iter_idx), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_aborted", 32'(aborted), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);
    endtask

    // Plans one loop from m_mask/m_dly. Plan index k is the value sampled at relative edge k;
    // the accepted start is edge 0. Iterations listed as abort/timeout end the run there.
    task automatic run(input int n, input int timeout_iter, input int abort_iter,
                       input int abort_off, input int reset_rel);
        ev_t evs[$];
        ev_t ev;
        int  e, s, d, a, end_idx, t0, key, len;
        bit  fin;
        pl_start.delete(); pl_cz.delete(); pl_ad.delete(); pl_ab.delete(); pl_cnt.delete();
        ensure(0);
        pl_start[0] = 1'b1;
        pl_cnt[0]   = n;
        pl_ab[0]    = 1'($urandom);
        pl_ad[0]    = 1'($urandom);
        fin = 1'b0;
        end_idx = 0;
        e = 0;
        if (n == 0) begin
            evs.push_back(mk_ev(K_DONE, 0, m_key, m_idx, m_terr, 1'b0));
        end else begin
            m_terr = 1'b0;
            for (int i = 0; i < n && !fin; i++) begin
                key = (i * KEY_STRIDE) % (1 << KEY_ADDR_W);
                ensure(e + 1);
                pl_cz[e+1] = (m_mask[i] != 0);
                pl_ad[e+1] = 1'($urandom);
                m_key = key;
                m_idx = i;
                if (m_mask[i] != 0) begin
                    e = e + 2;
                end else begin
                    s = e + 1;
                    evs.push_back(mk_ev(K_START, s, key, i, 1'b0, 1'b1));
                    if (i == timeout_iter) begin
                        a = s + WD_LIMIT;
                        ensure(a);
                        m_terr = 1'b1;
                        evs.push_back(mk_ev(K_ABORT, a, key, i, 1'b1, 1'b0));
                        end_idx = a;
                        fin = 1'b1;
                    end else if (i == abort_iter) begin
                        a = s + abort_off;
                        ensure(a);
                        pl_ab[a] = 1'b1;
                        pl_ad[a] = 1'($urandom);
                        evs.push_back(mk_ev(K_ABORT, a, key, i, m_terr, 1'b0));
                        end_idx = a;
                        fin = 1'b1;
                    end else begin
                        d = s + m_dly[i];
                        ensure(d);
                        pl_ad[d] = 1'b1;
                        e = d + 1;
                    end
                end
            end
            if (!fin) begin
                evs.push_back(mk_ev(K_DONE, e, m_key, m_idx, m_terr, 1'b1));
                end_idx = e + 1;
                ensure(end_idx);
            end
            // Starts while busy must be ignored.
            for (int k = 1; k <= end_idx; k++) pl_start[k] = ($urandom_range(3, 0) == 0);
        end
        len = (reset_rel >= 0) ? reset_rel : end_idx + 1;
        @(negedge clk);
        t0 = cyc + 1;
        foreach (evs[j]) begin
            if (reset_rel < 0 || evs[j].edge_n < reset_rel) begin
                ev = evs[j];
                ev.edge_n = ev.edge_n + t0;
                sb.push_back(ev);
            end
        end
        for (int k = 0; k < len; k++) begin
            if (k > 0) @(negedge clk);
            drive(k);
        end
        if (reset_rel >= 0) begin
            @(negedge clk);
            #2;
            rst = 1'b1;
            start = 1'b0; abort = 1'b0; acc_done = 1'b0; coeff_zero = 1'b0;
            #1;
            chk_reset_outputs();
            m_key = 0;
            m_idx = 0;
            m_terr = 1'b0;
            repeat (2) @(negedge clk);
            rst = 1'b0;
        end
    endtask

    task automatic set_loop(input int n, input int dly);
        m_mask.delete();
        m_dly.delete();
        for (int i = 0; i < n; i++) begin
            m_mask.push_back(0);
            m_dly.push_back(dly);
        end
    endtask

    initial begin
        int n, ab_it;
        repeat (2) @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;
        idle(2);

        set_loop(3, 20);
        run(3, -1, -1, 0, -1);
        idle(3);
        chk("busy_after_loop", 32'(busy), 0);

        set_loop(4, 0);
        m_mask[1] = 1;
        foreach (m_dly[i]) m_dly[i] = int'($urandom_range(WD_LIMIT, 1));
        run(4, -1, -1, 0, -1);

        run(0, -1, -1, 0, -1);
        run(0, -1, -1, 0, -1);
        idle(2);

        set_loop(2, 5);
        run(2, 0, -1, 0, -1);
        idle(2);
        chk("timeout_err_sticky", 32'(timeout_err), 1);
        run(0, -1, -1, 0, -1);

        set_loop(2, 3);
        m_dly[0] = WD_LIMIT;
        run(2, -1, -1, 0, -1);
        idle(2);
        chk("timeout_err_cleared", 32'(timeout_err), 0);

        set_loop(3, 10);
        run(3, -1, 1, 7, -1);
        idle(1);
        chk("busy_after_abort", 32'(busy), 0);

        set_loop(5, 8);
        run(5, -1, -1, 0, 12);
        idle(1);
        set_loop(2, 4);
        m_dly[1] = 6;
        run(2, -1, -1, 0, -1);

        repeat (8) begin
            n = int'($urandom_range(8, 1));
            m_mask.delete();
            m_dly.delete();
            for (int i = 0; i < n; i++) begin
                m_mask.push_back(($urandom_range(2, 0) == 0) ? 1 : 0);
                m_dly.push_back(int'($urandom_range(WD_LIMIT, 1)));
            end
            ab_it = ($urandom_range(3, 0) == 0) ? int'($urandom_range(n - 1, 0)) : -1;
            run(n, -1, ab_it, int'($urandom_range(WD_LIMIT, 1)), -1);
            if ($urandom_range(1, 0) == 1) idle(int'($urandom_range(3, 1)));
        end

        // Maximum count, mostly skipped coefficients; iteration 512 wraps the key base to 0.
        set_loop(1023, 2);
        foreach (m_mask[i]) m_mask[i] = 1;
        m_mask[0] = 0; m_mask[511] = 0; m_mask[512] = 0; m_mask[1022] = 0;
        run(1023, -1, -1, 0, -1);

        idle(5);
        chk("scoreboard_empty", 32'(sb.size()), 0);
        chk("busy_at_end", 32'(busy), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
